// File: rtl/hack_uart_tx.sv
// Serializes 16-bit Hack words as two UART frames (low byte first, LSB first).
// Define HACK_UART_TX_PARITY_EN to switch framing from 8N1 to 8E1.
module hack_uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef HACK_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitIdx;
  logic             r_byteSel;
  logic [15:0]      r_data;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  state_t           w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [2:0]       w_bitIdxNext;
  logic             w_byteSelNext;
  logic [15:0]      w_dataNext;
  logic             w_busyNext;
  logic             w_doneNext;
  logic             w_txNext;
  logic             w_bitEnd;
  logic [7:0]       w_byteNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitIdx  <= '0;
      r_byteSel <= 1'b0;
      r_data    <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_bitIdx  <= w_bitIdxNext;
      r_byteSel <= w_byteSelNext;
      r_data    <= w_dataNext;
      r_tx      <= w_txNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  // The counter spans one bit period; every state change happens on its last cycle.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_bitIdxNext  = r_bitIdx;
    w_byteSelNext = r_byteSel;
    w_dataNext    = r_data;
    w_busyNext    = r_busy;
    w_doneNext    = 1'b0;
    w_bitEnd      = (r_cnt == CNT_LAST);

    if (r_state != S_IDLE) begin
      w_cntNext = w_bitEnd ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_stateNext   = S_START;
          w_cntNext     = '0;
          w_byteSelNext = 1'b0;
          w_dataNext    = in;
          w_busyNext    = 1'b1;
        end
      end
      S_START: begin
        if (w_bitEnd) begin
          w_stateNext  = S_DATA;
          w_bitIdxNext = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          if (r_bitIdx == 3'd7) begin
`ifdef HACK_UART_TX_PARITY_EN
            w_stateNext = S_PARITY;
`else
            w_stateNext = S_STOP;
`endif
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end
`ifdef HACK_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bitEnd) begin
          if (!r_byteSel) begin
            w_byteSelNext = 1'b1;
            w_stateNext   = S_START;
          end else begin
            w_stateNext = S_IDLE;
            w_busyNext  = 1'b0;
            w_doneNext  = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  // tx is registered from the next state, so the start bit appears right after acceptance.
  always_comb begin
    w_byteNext = w_byteSelNext ? w_dataNext[15:8] : w_dataNext[7:0];
    w_txNext   = 1'b1;
    case (w_stateNext)
      S_START:  w_txNext = 1'b0;
      S_DATA:   w_txNext = w_byteNext[w_bitIdxNext];
`ifdef HACK_UART_TX_PARITY_EN
      S_PARITY: w_txNext = ^w_byteNext;
`endif
      default:  w_txNext = 1'b1;
    endcase
  end

  assign in_ready = (r_state == S_IDLE) && !rst;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
